// File: rtl/frogger_pkg.sv
// frogger_pkg: shared constants and types for the Frogger game-state core.
//   DEF_COLS / DEF_ROWS : default grid size (16 x 8)
//   LANE_INIT           : initial car pattern, rows 1..6 packed row 1 at bits [15:0]
//   move_t              : decoded move request
//   pick_move()         : resolves simultaneous presses, up > down > left > right
package frogger_pkg;

    localparam int DEF_COLS = 16;
    localparam int DEF_ROWS = 8;

    localparam logic [15:0] LANE_INIT_R1 = 16'h8080;
    localparam logic [15:0] LANE_INIT_R2 = 16'h3000;
    localparam logic [15:0] LANE_INIT_R3 = 16'h0C0C;
    localparam logic [15:0] LANE_INIT_R4 = 16'h0700;
    localparam logic [15:0] LANE_INIT_R5 = 16'h4444;
    localparam logic [15:0] LANE_INIT_R6 = 16'hC000;

    localparam logic [95:0] LANE_INIT = {LANE_INIT_R6, LANE_INIT_R5, LANE_INIT_R4,
                                         LANE_INIT_R3, LANE_INIT_R2, LANE_INIT_R1};

    typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_t;

    function automatic move_t pick_move(input logic up, input logic down,
                                        input logic left, input logic right);
        if (up)    return MV_UP;
        if (down)  return MV_DOWN;
        if (left)  return MV_LEFT;
        if (right) return MV_RIGHT;
        return MV_NONE;
    endfunction

endpackage

// File: rtl/frogger_if.sv
// frogger_if: buttons in, game state out.
//   up/down/left/right : active-low raw buttons (asynchronous, idle high)
//   frog_x/frog_y      : frog position
//   lanes              : car occupancy, bit (r-1)*COLS+c = car at row r, column c
//   score/lives        : goals reached (saturating) and remaining lives
//   collision          : one-cycle pulse on a hit
//   game_over          : high once lives reach 0
// Modports: slave = game core, master = button source / display side.
interface frogger_if
    import frogger_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) ();
    logic                       up;
    logic                       down;
    logic                       left;
    logic                       right;
    logic [$clog2(COLS)-1:0]    frog_x;
    logic [$clog2(ROWS)-1:0]    frog_y;
    logic [(ROWS-2)*COLS-1:0]   lanes;
    logic [7:0]                 score;
    logic [1:0]                 lives;
    logic                       collision;
    logic                       game_over;

    modport master (
        output up, down, left, right,
        input  frog_x, frog_y, lanes, score, lives, collision, game_over
    );

    modport slave (
        input  up, down, left, right,
        output frog_x, frog_y, lanes, score, lives, collision, game_over
    );
endinterface

// File: rtl/frogger_btn.sv
// frogger_btn: 2-flop synchronizer plus falling-edge detector for one
// active-low button.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : raw asynchronous button, idle high
//   press      : one-cycle pulse per high-to-low transition
// The first rising edge that sees btn low loads sync[0]; press is high
// after the second edge, so the consumer acts on the third.
module frogger_btn (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    // sync[1:0] is the synchronizer, sync[2] the previous synchronized level
    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (reset) sync <= 3'b111;   // idle-high so reset never fakes a press
        else       sync <= {sync[1:0], btn};
    end

    assign press = sync[2] & ~sync[1];
endmodule

// File: rtl/frogger.sv
// frogger_core: game-state core of Frogger.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears everything incl. buttons
//   bus   : frogger_if.slave, buttons in and registered game state out
// Parameters: COLS, ROWS, TICK_DIV (cycles per car step, >= 4), LIVES (1..3).
// Optional macro FROGGER_SPEEDUP_EN: each goal shortens the car period by
// TICK_DIV/8 cycles, floored at TICK_DIV/4; reset restores TICK_DIV.
module frogger_core
    import frogger_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int TICK_DIV = 50,
    parameter int LIVES    = 3
) (
    input logic      clk,
    input logic      reset,
    frogger_if.slave bus
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int NL = ROWS - 2;
    localparam int TW = $clog2(TICK_DIV + 1);

    localparam logic [XW-1:0] START_X     = XW'(COLS / 2);
    localparam logic [XW-1:0] X_MAX       = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST_LANE = YW'(ROWS - 2);
    localparam logic [TW-1:0] PERIOD_FULL = TW'(TICK_DIV);

    // Lane r (0-based here, grid row r+1) reuses the 16-bit seed patterns
    // cyclically so other grid sizes still start with traffic.
    function automatic logic [NL-1:0][COLS-1:0] lanes_reset();
        logic [NL-1:0][COLS-1:0] v;
        for (int r = 0; r < NL; r++)
            for (int c = 0; c < COLS; c++)
                v[r][c] = LANE_INIT[(r % 6) * 16 + (c % 16)];
        return v;
    endfunction
    localparam logic [NL-1:0][COLS-1:0] LANES_RST = lanes_reset();

    logic [XW-1:0]           frog_x_q;
    logic [YW-1:0]           frog_y_q;
    logic [NL-1:0][COLS-1:0] lane_q;
    logic [NL-1:0][COLS-1:0] lane_step;
    logic [TW-1:0]           tick_q;
    logic [TW-1:0]           period;
    logic [7:0]              score_q;
    logic [1:0]              lives_q;
    logic                    collision_q;
    logic                    game_over_q;

    logic press_up, press_down, press_left, press_right;
    logic hit, goal, tick_wrap;
    logic [YW-1:0] row_idx;
    move_t mv;

    frogger_btn u_btn_up    (.clk(clk), .reset(reset), .btn(bus.up),    .press(press_up));
    frogger_btn u_btn_down  (.clk(clk), .reset(reset), .btn(bus.down),  .press(press_down));
    frogger_btn u_btn_left  (.clk(clk), .reset(reset), .btn(bus.left),  .press(press_left));
    frogger_btn u_btn_right (.clk(clk), .reset(reset), .btn(bus.right), .press(press_right));

    assign mv = pick_move(press_up, press_down, press_left, press_right);

    // Index i is grid row i+1: odd grid rows drift toward column 0,
    // even grid rows toward column COLS-1, both wrapping.
    for (genvar i = 0; i < NL; i++) begin : g_lane
        if (i % 2 == 0) begin : g_odd_row
            assign lane_step[i] = {lane_q[i][0], lane_q[i][COLS-1:1]};
        end else begin : g_even_row
            assign lane_step[i] = {lane_q[i][COLS-2:0], lane_q[i][COLS-1]};
        end
    end

    // Hit is judged on registered state only, so a car stepping onto the
    // frog is seen one cycle after the step.
    always_comb begin
        hit     = 1'b0;
        row_idx = frog_y_q - 1'b1;
        if (frog_y_q != '0 && frog_y_q <= Y_LAST_LANE)
            hit = lane_q[row_idx][frog_x_q];
    end

    assign goal      = !game_over_q && !hit && (mv == MV_UP) && (frog_y_q == Y_LAST_LANE);
    // >= rather than == so a period shortened below the running count wraps at once
    assign tick_wrap = (tick_q >= period - 1'b1);

`ifdef FROGGER_SPEEDUP_EN
    localparam logic [TW-1:0] PERIOD_STEP = TW'(TICK_DIV / 8);
    localparam logic [TW-1:0] PERIOD_MIN  = TW'(TICK_DIV / 4);
    logic [TW-1:0] period_q;

    always_ff @(posedge clk) begin
        if (reset)
            period_q <= PERIOD_FULL;
        else if (goal)
            period_q <= (period_q >= PERIOD_MIN + PERIOD_STEP) ? period_q - PERIOD_STEP
                                                                : PERIOD_MIN;
    end
    assign period = period_q;
`else
    assign period = PERIOD_FULL;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            frog_x_q    <= START_X;
            frog_y_q    <= '0;
            lane_q      <= LANES_RST;
            tick_q      <= '0;
            score_q     <= '0;
            lives_q     <= 2'(LIVES);
            collision_q <= 1'b0;
            game_over_q <= 1'b0;
        end else if (game_over_q) begin
            // frozen until reset; only the pulse is cleared
            collision_q <= 1'b0;
        end else begin
            if (tick_wrap) begin
                tick_q <= '0;
                lane_q <= lane_step;
            end else begin
                tick_q <= tick_q + 1'b1;
            end

            collision_q <= hit;
            if (hit) begin
                // any press arriving this cycle is dropped
                lives_q  <= lives_q - 2'd1;
                frog_x_q <= START_X;
                frog_y_q <= '0;
                if (lives_q == 2'd1) game_over_q <= 1'b1;
            end else begin
                case (mv)
                    MV_UP: begin
                        if (goal) begin
                            frog_x_q <= START_X;
                            frog_y_q <= '0;
                            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                        end else begin
                            frog_y_q <= frog_y_q + 1'b1;
                        end
                    end
                    MV_DOWN:  if (frog_y_q != '0)    frog_y_q <= frog_y_q - 1'b1;
                    MV_LEFT:  if (frog_x_q != '0)    frog_x_q <= frog_x_q - 1'b1;
                    MV_RIGHT: if (frog_x_q != X_MAX) frog_x_q <= frog_x_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.frog_x    = frog_x_q;
    assign bus.frog_y    = frog_y_q;
    assign bus.lanes     = lane_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.collision = collision_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_frogger_core.sv
// tb_frogger_core: scoreboard bench for frogger_core.
// dut_a (TICK_DIV=1000) covers moves, saturation, priority and a goal
// before any car step happens. dut_b (TICK_DIV=4) covers hits and game
// over with hit cycles worked out by hand from the lane rotation.
module tb_frogger_core;
    import frogger_pkg::*;

    typedef struct packed {
        logic [3:0] x;
        logic [2:0] y;
        logic [7:0] score;
        logic [1:0] lives;
        logic       go;
    } st_t;

    typedef struct {
        st_t         s;
        int          cyc;
        bit          snap;
        bit          chk_lanes;
        logic [95:0] lanes;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;
    bit   armed = 0;

    exp_t qa[$];
    exp_t qb[$];
    int   cq_b[$];

    st_t  ca, cb, pa, pb;
    exp_t e;
    int   ccyc;

    logic [95:0] L_INIT   = {16'hC000, 16'h4444, 16'h0700, 16'h0C0C, 16'h3000, 16'h8080};
    // lanes after 23 steps: odd rows shifted 7 toward col 0, even rows 7 toward col 15
    logic [95:0] L_FROZEN = {16'h0060, 16'h8888, 16'h8003, 16'h1818, 16'h0018, 16'h0101};

    frogger_if #(.COLS(16), .ROWS(8)) ifa ();
    frogger_if #(.COLS(16), .ROWS(8)) ifb ();

    frogger_core #(.COLS(16), .ROWS(8), .TICK_DIV(1000), .LIVES(3)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    frogger_core #(.COLS(16), .ROWS(8), .TICK_DIV(4), .LIVES(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input string tag, input int x, input int y, input int sc,
                                input int lv, input int go, input int at, input bit snap,
                                input bit chk, input logic [95:0] lanes);
        exp_t r;
        r.tag = tag;
        r.s.x = 4'(x);
        r.s.y = 3'(y);
        r.s.score = 8'(sc);
        r.s.lives = 2'(lv);
        r.s.go = 1'(go);
        r.cyc = at;
        r.snap = snap;
        r.chk_lanes = chk;
        r.lanes = lanes;
        return r;
    endfunction

    task automatic check_exp(input string who, input exp_t x, input st_t act,
                             input logic [95:0] lanes, input bit is_change);
        checks++;
        if (act !== x.s) begin
            failures++;
            $display("FAIL %s/%s state: got x=%0d y=%0d score=%0d lives=%0d go=%0b, want x=%0d y=%0d score=%0d lives=%0d go=%0b",
                     who, x.tag, act.x, act.y, act.score, act.lives, act.go,
                     x.s.x, x.s.y, x.s.score, x.s.lives, x.s.go);
        end
        if (is_change && x.cyc >= 0) begin
            checks++;
            if (cyc != x.cyc) begin
                failures++;
                $display("FAIL %s/%s timing: got cycle %0d, want cycle %0d", who, x.tag, cyc, x.cyc);
            end
        end
        if (x.chk_lanes) begin
            checks++;
            if (lanes !== x.lanes) begin
                failures++;
                $display("FAIL %s/%s lanes: got %h, want %h", who, x.tag, lanes, x.lanes);
            end
        end
    endtask

    task automatic unexpected(input string who, input st_t act);
        checks++;
        failures++;
        $display("FAIL %s unexpected_change: got x=%0d y=%0d score=%0d lives=%0d go=%0b, want no change",
                 who, act.x, act.y, act.score, act.lives, act.go);
    endtask

    // Monitor: a change of frog/score/lives/game_over is the DUT presenting
    // an output; it pops the next expectation. Snapshots pop at their cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            ca = {ifa.frog_x, ifa.frog_y, ifa.score, ifa.lives, ifa.game_over};
            cb = {ifb.frog_x, ifb.frog_y, ifb.score, ifb.lives, ifb.game_over};
            if (!armed) begin
                pa = ca;
                pb = cb;
                armed = 1;
            end

            if (ca !== pa) begin
                if (qa.size() == 0) unexpected("a", ca);
                else begin e = qa.pop_front(); check_exp("a", e, ca, ifa.lanes, 1'b1); end
            end else if (qa.size() > 0 && qa[0].snap && cyc >= qa[0].cyc) begin
                e = qa.pop_front();
                check_exp("a", e, ca, ifa.lanes, 1'b0);
            end

            if (cb !== pb) begin
                if (qb.size() == 0) unexpected("b", cb);
                else begin e = qb.pop_front(); check_exp("b", e, cb, ifb.lanes, 1'b1); end
            end else if (qb.size() > 0 && qb[0].snap && cyc >= qb[0].cyc) begin
                e = qb.pop_front();
                check_exp("b", e, cb, ifb.lanes, 1'b0);
            end

            if (ifa.collision) begin
                checks++;
                failures++;
                $display("FAIL a collision: got pulse at cycle %0d, want none", cyc);
            end
            if (ifb.collision) begin
                checks++;
                if (cq_b.size() == 0) begin
                    failures++;
                    $display("FAIL b collision: got pulse at cycle %0d, want none", cyc);
                end else begin
                    ccyc = cq_b.pop_front();
                    if (ccyc != cyc) begin
                        failures++;
                        $display("FAIL b collision: got pulse at cycle %0d, want cycle %0d", cyc, ccyc);
                    end
                end
            end

            pa = ca;
            pb = cb;
        end
    end

    task automatic set_btn_a(input int b, input logic v);
        case (b)
            0: ifa.up = v;
            1: ifa.down = v;
            2: ifa.left = v;
            default: ifa.right = v;
        endcase
    endtask

    task automatic set_btn_b(input int b, input logic v);
        case (b)
            0: ifb.up = v;
            1: ifb.down = v;
            2: ifb.left = v;
            default: ifb.right = v;
        endcase
    endtask

    // Low for 'hold' cycles; a move lands on the 3rd edge that samples it low.
    task automatic press_a(input string tag, input int b, input int hold, input bit moves,
                           input int x, input int y, input int sc);
        @(negedge clk);
        set_btn_a(b, 1'b0);
        if (moves) qa.push_back(mk(tag, x, y, sc, 3, 0, cyc + 3, 0, 0, '0));
        repeat (hold) @(negedge clk);
        set_btn_a(b, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press_b_at(input int n, input int b);
        wait_cyc(n);
        set_btn_b(b, 1'b0);
        @(negedge clk);
        set_btn_b(b, 1'b1);
    endtask

    task automatic run_a();
        press_a("up1",   0, 1, 1, 8, 1, 0);
        press_a("up2",   0, 1, 1, 8, 2, 0);
        press_a("down1", 1, 1, 1, 8, 1, 0);
        press_a("down2", 1, 1, 1, 8, 0, 0);
        press_a("down_sat", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) press_a("left", 2, 1, 1, 7 - i, 0, 0);
        for (int i = 0; i < 2; i++) press_a("left_sat", 2, 1, 0, 0, 0, 0);
        press_a("right_held", 3, 20, 1, 1, 0, 0);
        // up and left together: only the up move is taken
        @(negedge clk);
        ifa.up = 1'b0;
        ifa.left = 1'b0;
        qa.push_back(mk("prio", 1, 1, 0, 3, 0, cyc + 3, 0, 0, '0));
        @(negedge clk);
        ifa.up = 1'b1;
        ifa.left = 1'b1;
        repeat (4) @(negedge clk);
        press_a("prio_down", 1, 1, 1, 1, 0, 0);
        // column 1 is clear of cars in every lane at this time
        for (int i = 1; i <= 6; i++) press_a("climb", 0, 1, 1, 1, i, 0);
        press_a("goal", 0, 1, 1, 8, 0, 1);
        @(negedge clk);
        qa.push_back(mk("end_a", 8, 0, 1, 3, 0, cyc + 2, 1, 0, '0));
        repeat (4) @(negedge clk);
    endtask

    // Reset released after edge 3; cars step on edges 7, 11, ... (3+4m).
    // Row 1 has a car at column 8 after steps 7, 15, 23 -> hits on 32, 64, 96.
    task automatic run_b();
        press_b_at(3, 0);     // frog to (8,1) on edge 6
        press_b_at(40, 0);    // back to row 1 on edge 43
        press_b_at(72, 0);    // back to row 1 on edge 75
        press_b_at(100, 0);   // game over: all ignored
        press_b_at(110, 3);
        press_b_at(120, 2);
        wait_cyc(145);
    endtask

    initial begin
        ifa.up = 1'b1; ifa.down = 1'b1; ifa.left = 1'b1; ifa.right = 1'b1;
        ifb.up = 1'b1; ifb.down = 1'b1; ifb.left = 1'b1; ifb.right = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        qa.push_back(mk("reset", 8, 0, 0, 3, 0, 4, 1, 1, L_INIT));
        qb.push_back(mk("reset", 8, 0, 0, 3, 0, 4, 1, 1, L_INIT));
        qb.push_back(mk("up_row1", 8, 1, 0, 3, 0, 6,  0, 0, '0));
        qb.push_back(mk("hit1",    8, 0, 0, 2, 0, 32, 0, 0, '0));
        qb.push_back(mk("up_row1", 8, 1, 0, 2, 0, 43, 0, 0, '0));
        qb.push_back(mk("hit2",    8, 0, 0, 1, 0, 64, 0, 0, '0));
        qb.push_back(mk("up_row1", 8, 1, 0, 1, 0, 75, 0, 0, '0));
        qb.push_back(mk("hit3",    8, 0, 0, 0, 1, 96, 0, 0, '0));
        qb.push_back(mk("frozen",  8, 0, 0, 0, 1, 140, 1, 1, L_FROZEN));
        cq_b.push_back(32);
        cq_b.push_back(64);
        cq_b.push_back(96);
        mon_en = 1;

        fork
            run_a();
            run_b();
        join

        repeat (3) @(negedge clk);
        checks++;
        if (qa.size() != 0) begin
            failures++;
            $display("FAIL a pending: got %0d expectations left, want 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            failures++;
            $display("FAIL b pending: got %0d expectations left, want 0", qb.size());
        end
        checks++;
        if (cq_b.size() != 0) begin
            failures++;
            $display("FAIL b collision_pending: got %0d pulses missing, want 0", cq_b.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time 100000, want finish");
        $fatal(1, "watchdog");
    end
endmodule
